// File: rtl/sequence_detector_moore.sv
// Moore FSM that detects PATTERN on a serial input, with overlapping matches.
// The number of matched bits is the state and is shown on an active-low 7-segment digit.
module sequence_detector_moore #(
  parameter logic [8:0] PATTERN     = 9'b000001011,
  parameter int         PATTERN_LEN = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sequence_in,
  output logic [6:0] LED_out
);

  localparam int SW     = $clog2(PATTERN_LEN + 1);
  localparam int TBL_SZ = 2 ** (SW + 1);

  // Longest pattern prefix that is a suffix of (first s pattern bits, then b).
  // Out-of-range states fall back to 0.
  function automatic logic [SW-1:0] next_state(input int s, input int b);
    int pat;
    int str;
    int len;
    int k;
    int found;
    pat   = int'(PATTERN);
    found = 0;
    if (s <= PATTERN_LEN) begin
      str = (((pat >> (PATTERN_LEN - s)) & ((1 << s) - 1)) << 1) | (b & 1);
      len = s + 1;
      for (k = 1; k <= PATTERN_LEN; k++) begin
        if (k <= len) begin
          if ((str & ((1 << k) - 1)) == ((pat >> (PATTERN_LEN - k)) & ((1 << k) - 1)))
            found = k;
        end
      end
    end
    return SW'(found);
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [SW-1:0] next_tbl [0:TBL_SZ-1];
  logic [SW-1:0] state_p0;

  for (genvar g = 0; g < TBL_SZ; g++) begin : g_tbl
    assign next_tbl[g] = next_state(g >> 1, g & 1);
  end

  // Stage 0: match-length register, indexed lookup into the elaborated table.
  always_ff @(posedge clock) begin
    if (!reset)
      state_p0 <= '0;
    else
      state_p0 <= next_tbl[{state_p0, sequence_in}];
  end

  assign LED_out = seg_decode(4'(state_p0));

endmodule

// File: tb/tb_sequence_detector_moore.sv
// Directed bench for sequence_detector_moore: default 1011 pattern and a 110 override.
module tb_sequence_detector_moore;

  localparam logic [6:0] D0 = 7'b0000001;
  localparam logic [6:0] D1 = 7'b1001111;
  localparam logic [6:0] D2 = 7'b0010010;
  localparam logic [6:0] D3 = 7'b0000110;
  localparam logic [6:0] D4 = 7'b1001100;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, din_a = 1'b0;
  logic       rst_b = 1'b0, din_b = 1'b0;
  logic [6:0] led_a, led_b;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  sequence_detector_moore dut_a (
    .clock(clk), .reset(rst_a), .sequence_in(din_a), .LED_out(led_a)
  );

  sequence_detector_moore #(.PATTERN(9'b000000110), .PATTERN_LEN(3)) dut_b (
    .clock(clk), .reset(rst_b), .sequence_in(din_b), .LED_out(led_b)
  );

  task automatic step_a(input logic r, input logic d, input logic [6:0] exp, input string tag);
    rst_a = r;
    din_a = d;
    @(posedge clk);
    #1;
    tests++;
    assert (led_a === exp) else begin
      fails++;
      $error("FAIL %s: LED_out=%b expected %b", tag, led_a, exp);
    end
  endtask

  task automatic step_b(input logic r, input logic d, input logic [6:0] exp, input string tag);
    rst_b = r;
    din_b = d;
    @(posedge clk);
    #1;
    tests++;
    assert (led_b === exp) else begin
      fails++;
      $error("FAIL %s: LED_out=%b expected %b", tag, led_b, exp);
    end
  endtask

  initial begin
    // Reset held with toggling input
    for (int i = 0; i < 5; i++) step_a(1'b0, 1'(i & 1), D0, "reset_hold");

    // First detect
    step_a(1'b1, 1'b1, D1, "m1011_b1");
    step_a(1'b1, 1'b0, D2, "m1011_b0");
    step_a(1'b1, 1'b1, D3, "m1011_b1b");
    step_a(1'b1, 1'b1, D4, "m1011_detect");

    // Overlapping second detect
    step_a(1'b1, 1'b1, D1, "ovl_b1");
    step_a(1'b1, 1'b0, D2, "ovl_b0");
    step_a(1'b1, 1'b1, D3, "ovl_b1b");
    step_a(1'b1, 1'b1, D4, "ovl_detect");

    // Leaving the detect state on a 0 falls back to the 10 border
    step_a(1'b1, 1'b0, D2, "post_detect_0");
    din_a = 1'b1;
    #2;
    tests++;
    assert (led_a === D2) else begin
      fails++;
      $error("FAIL moore_no_comb: LED_out=%b expected %b", led_a, D2);
    end

    // Failure paths from 0
    step_a(1'b0, 1'b0, D0, "rst1");
    step_a(1'b1, 1'b0, D0, "fp_0");
    step_a(1'b1, 1'b1, D1, "fp11_a");
    step_a(1'b1, 1'b1, D1, "fp11_b");
    step_a(1'b0, 1'b0, D0, "rst2");
    step_a(1'b1, 1'b1, D1, "fp100_a");
    step_a(1'b1, 1'b0, D2, "fp100_b");
    step_a(1'b1, 1'b0, D0, "fp100_c");
    step_a(1'b0, 1'b0, D0, "rst3");
    step_a(1'b1, 1'b1, D1, "fp1010_a");
    step_a(1'b1, 1'b0, D2, "fp1010_b");
    step_a(1'b1, 1'b1, D3, "fp1010_c");
    step_a(1'b1, 1'b0, D2, "fp1010_d");

    // Mid-sequence reset discards progress
    step_a(1'b0, 1'b0, D0, "rst4");
    step_a(1'b1, 1'b1, D1, "mid_a");
    step_a(1'b1, 1'b0, D2, "mid_b");
    step_a(1'b1, 1'b1, D3, "mid_c");
    step_a(1'b0, 1'b1, D0, "mid_reset");
    step_a(1'b1, 1'b1, D1, "mid_after");

    // Override pattern 110
    step_b(1'b0, 1'b1, D0, "b_reset");
    step_b(1'b1, 1'b1, D1, "b_1");
    step_b(1'b1, 1'b1, D2, "b_11");
    step_b(1'b1, 1'b1, D2, "b_111");
    step_b(1'b1, 1'b0, D3, "b_detect");
    step_b(1'b1, 1'b1, D1, "b_ovl_1");
    step_b(1'b1, 1'b1, D2, "b_ovl_11");
    step_b(1'b1, 1'b0, D3, "b_ovl_detect");
    step_b(1'b1, 1'b0, D0, "b_after_0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sequence_detector_moore.md
Name: sequence_detector_moore

Overview:
- Moore finite-state machine that detects a serial bit pattern on a 1-bit input, one bit per clock.
- Overlapping occurrences are detected.
- The current state is the number of pattern bits currently matched. It drives an active-low 7-segment display as a decimal digit.
- Used as the golden reference for FPGA-fabric sequence-detector tests and as a standalone demo block.

Parameters:
- PATTERN, 4'b1011: bit pattern to detect. The MSB is the first bit received.
- PATTERN_LEN, 4: number of valid bits in PATTERN. Legal range 1..9, so every state fits in one decimal digit.

Ports:
- clock, input, 1: single clock. All state changes happen on its rising edge.
- reset, input, 1: synchronous, active-low reset.
- sequence_in, input, 1: serial data bit, sampled on the rising edge of clock.
- LED_out, output, 7: active-low 7-segment code of the current state. Bit 6 = segment a, down to bit 0 = segment g.

Behaviour:
- State register S holds the match length, range 0..PATTERN_LEN. Width is ceil(log2(PATTERN_LEN+1)) bits, maximum 4.
- Reset:
  - On a rising clock edge with reset==0, S is set to 0.
  - Reset has priority over sequence_in.
  - After reset, LED_out = 7'b0000001 (digit "0").
- Before the first reset, S is undefined. The bench must apply reset before checking outputs.
- Transition, when reset==1, on each rising edge: S_next is the length of the longest prefix of PATTERN that is a suffix of the last S matched bits followed by sequence_in.
  - This is KMP/failure-function behaviour, so overlaps are kept.
  - From S==PATTERN_LEN, matching continues using the longest proper border of PATTERN.
- Transition table for the default 1011:

  | S | sequence_in=0 | sequence_in=1 |
  |---|---|---|
  | 0 | 0 | 1 |
  | 1 | 2 | 1 |
  | 2 | 0 | 3 |
  | 3 | 2 | 4 |
  | 4 | 2 | 1 |

- Transition logic is computed at elaboration from the parameters (generate loops or constant functions). No runtime pattern loading.
- Latency: LED_out is a combinational decode of S only (Moore). It updates after the same rising edge that updates S and never depends combinationally on sequence_in.
- "Detected" means S==PATTERN_LEN. The display then shows digit PATTERN_LEN and holds it for exactly one cycle per full match.
- Decode, active-low, gfedcba order as abcdefg = bits 6..0:

  | Digit | LED_out |
  |---|---|
  | 0 | 0000001 |
  | 1 | 1001111 |
  | 2 | 0010010 |
  | 3 | 0000110 |
  | 4 | 1001100 |
  | 5 | 0100100 |
  | 6 | 0100000 |
  | 7 | 0001111 |
  | 8 | 0000000 |
  | 9 | 0000100 |
  | any other S value | 1111111 (all segments off) |

- Reset mid-sequence: progress is discarded. The next non-reset edge evaluates from S=0, using that edge's sequence_in.
- A reset held low for many cycles keeps S=0 regardless of sequence_in.
- There are no illegal reachable states. If S ever holds a value greater than PATTERN_LEN, the next non-reset edge forces S to 0.

Test Plan:
- Reset: hold reset=0 for 5 cycles with sequence_in toggling -> LED_out=0000001 throughout.
- Release reset, drive 1,0,1,1 -> LED_out after each edge: 1001111, 0010010, 0000110, 1001100 (digit 4 = detect).
- Overlap: after the detect, drive 1 then 0,1,1 -> digits 1, 2, 3, 4, giving a second detect with 3 new bits after the prior 1.
- Failure paths from 0: drive 0 -> digit 0. Then:
  - 1,1 -> digits 1, 1.
  - 1,0,0 from 0 -> digits 1, 2, 0.
  - 1,0,1,0 -> digits 1, 2, 3, 2.
- Mid-sequence reset: drive 1,0,1, then reset=0 with sequence_in=1 for one edge -> digit 0. Release reset and drive 1 -> digit 1, not 4.
- Parameter override PATTERN=3'b110, PATTERN_LEN=3: drive 1,1,1,0 -> digits 1, 2, 2, 3. Then 1,1,0 -> digits 1, 2, 3.
